stream_argmax: RTL and testbench

STREAM_ARGMAX -- requirements
Module: stream_argmax

---
 rtl/dnn_argmax_pkg.sv | 22 ++
 rtl/argmax_update.sv | 39 +++
 rtl/stream_argmax.sv | 146 ++++++++++++++
 tb/tb_stream_argmax.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_argmax_pkg.sv
// Shared types and helpers for the streaming argmax blocks.
package dnn_argmax_pkg;

    // Widest score the helper below can describe.
    localparam int MAX_IN_BITS = 64;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } argmax_state_t;

    // Most negative two's-complement value of a 'bits'-wide score. The result
    // is wider than needed; callers truncate it to their own score width, which
    // leaves only the sign bit set.
    function automatic logic [MAX_IN_BITS-1:0] most_neg(input int bits);
        logic [MAX_IN_BITS-1:0] v;
        v = '1;
        v = v << (bits - 1);
        return v;
    endfunction

endpackage

// File: rtl/argmax_update.sv
// One step of the running argmax: folds a single score into the
// (best, second, best_idx) triple. Purely combinational so that wider
// multi-lane variants can chain several copies in one cycle.
module argmax_update #(
    parameter int IN_BITS  = 16,
    parameter int IDX_BITS = 4
) (
    input  logic [IN_BITS-1:0]  i_best,
    input  logic [IN_BITS-1:0]  i_second,
    input  logic [IDX_BITS-1:0] i_best_idx,
    input  logic [IN_BITS-1:0]  i_score,
    input  logic [IDX_BITS-1:0] i_idx,
    output logic [IN_BITS-1:0]  o_best,
    output logic [IN_BITS-1:0]  o_second,
    output logic [IDX_BITS-1:0] o_best_idx
);

    logic w_gt_best;
    logic w_gt_second;

    assign w_gt_best   = $signed(i_score) > $signed(i_best);
    assign w_gt_second = $signed(i_score) > $signed(i_second);

    // Strictly-greater keeps the earliest index on ties; an equal score
    // still qualifies as runner-up, which yields a zero margin.
    always_comb begin
        o_best     = i_best;
        o_second   = i_second;
        o_best_idx = i_best_idx;
        if (w_gt_best) begin
            o_best     = i_score;
            o_second   = i_best;
            o_best_idx = i_idx;
        end else if (w_gt_second) begin
            o_second   = i_score;
        end
    end

endmodule

// File: rtl/stream_argmax.sv
// Streaming argmax over fixed-length frames of signed scores. Each frame is
// NUM_CLASSES beats; the result (index, max, margin to runner-up, framing
// error) is registered and held until downstream takes it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ACCUM | accepting beats, in_ready=1, folding scores into best/second
//   ST_HOLD  | result registered on outputs, out_valid=1, input stalled
module stream_argmax
    import dnn_argmax_pkg::*;
#(
    parameter int IN_BITS     = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_BITS    = $clog2(NUM_CLASSES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_BITS-1:0] out_idx,
    output logic [IN_BITS-1:0]  out_max,
    output logic [IN_BITS:0]    out_margin,
    output logic                out_err
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);
    localparam logic [IN_BITS-1:0]  MOST_NEG = IN_BITS'(most_neg(IN_BITS));

    argmax_state_t r_state;
    argmax_state_t w_state_nxt;

    logic [IDX_BITS-1:0] r_cnt;
    logic [IN_BITS-1:0]  r_best;
    logic [IN_BITS-1:0]  r_second;
    logic [IDX_BITS-1:0] r_best_idx;
    logic                r_err;

    logic [IDX_BITS-1:0] r_out_idx;
    logic [IN_BITS-1:0]  r_out_max;
    logic [IN_BITS:0]    r_out_margin;
    logic                r_out_err;

    logic                w_beat;
    logic                w_first;
    logic                w_close;
    logic                w_err_beat;
    logic [IN_BITS-1:0]  w_upd_best;
    logic [IN_BITS-1:0]  w_upd_second;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [IN_BITS-1:0]  w_nxt_best;
    logic [IN_BITS-1:0]  w_nxt_second;
    logic [IDX_BITS-1:0] w_nxt_idx;
    logic [IN_BITS:0]    w_margin;

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);

    assign w_beat  = in_valid && in_ready;
    assign w_first = (r_cnt == '0);
    assign w_close = (r_cnt == LAST_IDX);

    // in_last only flags framing errors; the counter alone ends a frame.
    assign w_err_beat = w_close ? ~in_last : in_last;

    argmax_update #(
        .IN_BITS  (IN_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_update (
        .i_best     (r_best),
        .i_second   (r_second),
        .i_best_idx (r_best_idx),
        .i_score    (in_data),
        .i_idx      (r_cnt),
        .o_best     (w_upd_best),
        .o_second   (w_upd_second),
        .o_best_idx (w_upd_idx)
    );

    // Class 0 seeds the accumulators instead of being compared against stale state.
    assign w_nxt_best   = w_first ? in_data  : w_upd_best;
    assign w_nxt_second = w_first ? MOST_NEG : w_upd_second;
    assign w_nxt_idx    = w_first ? '0       : w_upd_idx;

    // Sign-extend by one bit so max - min of the score range cannot overflow.
    assign w_margin = {w_nxt_best[IN_BITS-1], w_nxt_best}
                    - {w_nxt_second[IN_BITS-1], w_nxt_second};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: close on the final counted beat, reopen on the output handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_beat && w_close) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready)         w_state_nxt = ST_ACCUM;
            default:                         w_state_nxt = ST_ACCUM;
        endcase
    end

    // Accumulate scores per beat; capture the result when the frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_best       <= '0;
            r_second     <= '0;
            r_best_idx   <= '0;
            r_err        <= 1'b0;
            r_out_idx    <= '0;
            r_out_max    <= '0;
            r_out_margin <= '0;
            r_out_err    <= 1'b0;
        end else if (w_beat) begin
            r_best     <= w_nxt_best;
            r_second   <= w_nxt_second;
            r_best_idx <= w_nxt_idx;
            if (w_close) begin
                r_cnt        <= '0;
                r_err        <= 1'b0;
                r_out_idx    <= w_nxt_idx;
                r_out_max    <= w_nxt_best;
                r_out_margin <= w_margin;
                r_out_err    <= r_err | w_err_beat;
            end else begin
                r_cnt <= r_cnt + IDX_BITS'(1);
                r_err <= r_err | w_err_beat;
            end
        end
    end

    assign out_idx    = r_out_idx;
    assign out_max    = r_out_max;
    assign out_margin = r_out_margin;
    assign out_err    = r_out_err;

endmodule

// File: tb/tb_stream_argmax.sv
// Self-checking bench for stream_argmax: a 10-class instance for most
// scenarios plus a 4-class instance for the full-range margin case.
module tb_stream_argmax;

    localparam int N  = 10;
    localparam int N4 = 4;

    typedef struct {
        int idx;
        int mx;
        int margin;
        bit err;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic [15:0] out_max;
    logic [16:0] out_margin;
    logic        out_err;

    logic        in_valid4;
    logic        in_ready4;
    logic [15:0] in_data4;
    logic        in_last4;
    logic        out_valid4;
    logic        out_ready4;
    logic [1:0]  out_idx4;
    logic [15:0] out_max4;
    logic [16:0] out_margin4;
    logic        out_err4;

    exp_t q[$];
    exp_t q4[$];
    int   checks = 0;
    int   errors = 0;

    stream_argmax #(.IN_BITS(16), .NUM_CLASSES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_max    (out_max),
        .out_margin (out_margin),
        .out_err    (out_err)
    );

    stream_argmax #(.IN_BITS(16), .NUM_CLASSES(N4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_data    (in_data4),
        .in_last    (in_last4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_idx    (out_idx4),
        .out_max    (out_max4),
        .out_margin (out_margin4),
        .out_err    (out_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: earliest maximum, then the best of all other entries.
    function automatic exp_t model(input int sc[N], input logic [N-1:0] lastmask);
        exp_t e;
        int   run;
        e.idx = 0;
        e.mx  = sc[0];
        for (int i = 1; i < N; i++) begin
            if (sc[i] > e.mx) begin
                e.mx  = sc[i];
                e.idx = i;
            end
        end
        run = -32768;
        for (int j = 0; j < N; j++) begin
            if (j != e.idx && sc[j] > run) run = sc[j];
        end
        e.margin = e.mx - run;
        e.err    = (lastmask != {1'b1, {(N-1){1'b0}}});
        return e;
    endfunction

    // Drive one beat (entered at a falling edge) and wait for it to transfer.
    task automatic beat(input int d, input bit l, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'(d);
        in_last  = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: in_ready=%0b required 1 after %0d cycles", in_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int sc[N], input logic [N-1:0] lastmask, input int maxgap);
        q.push_back(model(sc, lastmask));
        for (int i = 0; i < N; i++) begin
            beat(sc[i], lastmask[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    // Accept one result from the 10-class instance and check it against the scoreboard.
    task automatic collect(input string tag, input int delay);
        exp_t e;
        int   n;
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%0b required 1", tag, out_valid);
            out_ready = 1'b0;
            return;
        end
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: result with empty scoreboard, idx=%0d", tag, out_idx);
        end else begin
            e = q.pop_front();
            checks++;
            if (out_idx !== 4'(e.idx)) begin
                errors++;
                $display("FAIL %s_idx: got %0d required %0d", tag, out_idx, e.idx);
            end
            checks++;
            if (out_max !== 16'(e.mx)) begin
                errors++;
                $display("FAIL %s_max: got %0d required %0d", tag, $signed(out_max), e.mx);
            end
            checks++;
            if (out_margin !== 17'(e.margin)) begin
                errors++;
                $display("FAIL %s_margin: got %0d required %0d", tag, out_margin, e.margin);
            end
            checks++;
            if (out_err !== e.err) begin
                errors++;
                $display("FAIL %s_err: got %0b required %0b", tag, out_err, e.err);
            end
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0/1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_idx !== 4'd0 || out_max !== 16'd0 || out_margin !== 17'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: idx=%0d max=%0d margin=%0d err=%0b required all 0",
                     out_idx, out_max, out_margin, out_err);
        end
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut4: in_ready=%0b out_valid=%0b required 1/0", in_ready4, out_valid4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int sc[N] = '{3, 9, -2, 9, 0, 1, 1, 7, -5, 4};
        send_frame(sc, 10'b10_0000_0000, 0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: out_valid=%0b in_ready=%0b required 1/0 one cycle after last beat",
                     out_valid, in_ready);
        end
        collect("basic", 0);
    endtask

    task automatic test_extremes();
        int   sc[N4] = '{-32768, 32767, -32768, -32768};
        exp_t e;
        int   n;
        e.idx = 1; e.mx = 32767; e.margin = 65535; e.err = 1'b0;
        q4.push_back(e);
        for (int i = 0; i < N4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 16'(sc[i]);
            in_last4  = (i == N4 - 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid4 = 1'b0;
        in_last4  = 1'b0;
        out_ready4 = 1'b1;
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = q4.pop_front();
        checks++;
        if (out_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL ext_timeout: out_valid=%0b required 1", out_valid4);
        end
        checks++;
        if (out_idx4 !== 2'(e.idx) || out_max4 !== 16'(e.mx)) begin
            errors++;
            $display("FAIL ext_idx_max: got %0d/%0d required %0d/%0d",
                     out_idx4, $signed(out_max4), e.idx, e.mx);
        end
        checks++;
        if (out_margin4 !== 17'(e.margin)) begin
            errors++;
            $display("FAIL ext_margin: got %0d required %0d", out_margin4, e.margin);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    task automatic test_all_equal();
        int sc[N];
        for (int i = 0; i < N; i++) sc[i] = -7;
        send_frame(sc, 10'b10_0000_0000, 1);
        collect("equal", 2);
    endtask

    task automatic test_backpressure();
        int   s1[N] = '{-100, -50, 20, 19, 21, 0, 5, 21, -1, 3};
        int   s2[N] = '{500, 400, 600, 300, 200, 100, 0, -100, 601, 599};
        exp_t e;
        send_frame(s1, 10'b10_0000_0000, 0);
        e = q[0];
        in_valid = 1'b1;
        in_data  = 16'(s2[0]);
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall%0d: in_ready=%0b out_valid=%0b required 0/1", c, in_ready, out_valid);
            end
            checks++;
            if (out_idx !== 4'(e.idx) || out_max !== 16'(e.mx) || out_margin !== 17'(e.margin)
                || out_err !== e.err) begin
                errors++;
                $display("FAIL bp_hold%0d: idx=%0d max=%0d margin=%0d required %0d/%0d/%0d",
                         c, out_idx, $signed(out_max), out_margin, e.idx, e.mx, e.margin);
            end
            @(negedge clk);
        end
        collect("bp", 0);
        send_frame(s2, 10'b10_0000_0000, 0);
        collect("bp_next", 1);
    endtask

    task automatic test_framing();
        int sc[N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send_frame(sc, 10'b00_0001_0000, 0);
        collect("frame_err", 0);
        send_frame(sc, 10'b10_0000_0000, 2);
        collect("frame_clean", 0);
    endtask

    task automatic test_reset_mid();
        int sc[N] = '{-3, -9, -1, -4, -1, -20, -2, -8, -30, -1};
        for (int i = 0; i < 7; i++) beat(100 + i, 1'b0, 0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 4'd0 || out_max !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: out_valid=%0b in_ready=%0b idx=%0d max=%0d required 0/1/0/0",
                     out_valid, in_ready, out_idx, out_max);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(sc, 10'b10_0000_0000, 0);
        collect("rstmid", 0);
    endtask

    task automatic test_random();
        int sc[N];
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f < 4) sc[i] = int'($urandom_range(0, 6)) - 3;
                else       sc[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            send_frame(sc, 10'b10_0000_0000, 2);
            collect("rand", int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        in_last4   = 1'b0;
        out_ready4 = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_all_equal();
        test_backpressure();
        test_framing();
        test_reset_mid();
        test_random();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
